led_frame_scheduler: RTL and testbench

// - Arbitrates frames from two requesters (visualizer, diagnostic pattern source) onto the single
//   WS2801 LED driver datapath. Sits between those sources and the driver.
// - Latches the granted frame, runs the driver start/done handshake, and enforces a minimum frame

---
 rtl/led_frame_scheduler_if.sv | 30 +++
 rtl/led_frame_scheduler.sv | 141 ++++++++++++++
 tb/tb_led_frame_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_frame_scheduler_if.sv
// Frame-request and LED-driver bundle between the requesters, the scheduler and the WS2801 driver.
// Latency: none (wiring only).
// Backpressure: requester valids are held until the matching single-cycle ready pulse.
interface led_frame_scheduler_if #(
  parameter int LEDS = 50
);
  logic                  vis_valid;
  logic [24*LEDS-1:0]    vis_rgb;
  logic                  vis_ready;
  logic                  diag_valid;
  logic [24*LEDS-1:0]    diag_rgb;
  logic                  diag_ready;
  logic                  drv_start;
  logic [24*LEDS-1:0]    drv_rgb;
  logic                  drv_done;
  logic [1:0]            frame_src;
  logic [15:0]           frames_sent;

  // Scheduler side
  modport master (
    input  vis_valid, vis_rgb, diag_valid, diag_rgb, drv_done,
    output vis_ready, diag_ready, drv_start, drv_rgb, frame_src, frames_sent
  );

  // Requesters and driver side
  modport slave (
    output vis_valid, vis_rgb, diag_valid, diag_rgb, drv_done,
    input  vis_ready, diag_ready, drv_start, drv_rgb, frame_src, frames_sent
  );
endinterface

// File: rtl/led_frame_scheduler.sv
// Round-robin vis/diag frame arbiter with blank-frame insertion, feeding one WS2801 driver.
// Latency: ready/drv_start/drv_rgb register one cycle after the accept cycle.
// Backpressure: accepts only in IDLE with holdoff expired; otherwise valids are held off.
module led_frame_scheduler #(
  parameter int LEDS             = 50,
  parameter int MIN_FRAME_CYCLES = 12500,
  parameter int BLANK_CYCLES     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  led_frame_scheduler_if.master   bus
);
  localparam int W  = 24 * LEDS;
  localparam int HW = (MIN_FRAME_CYCLES > 1) ? $clog2(MIN_FRAME_CYCLES) : 1;
  localparam int IW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_VIS   = 2'b01;
  localparam logic [1:0] SRC_DIAG  = 2'b10;
  localparam logic [1:0] SRC_BLANK = 2'b11;

  typedef enum logic [1:0] {IDLE, ARM, BUSY} state_e;

  state_e         state_q, state_d;
  logic [HW-1:0]  holdoff_q, holdoff_d;
  logic [IW-1:0]  idle_cnt_q, idle_cnt_d;
  logic           blank_sent_q, blank_sent_d;
  logic           last_diag_q, last_diag_d;
  logic [W-1:0]   drv_rgb_q, drv_rgb_d;
  logic [1:0]     frame_src_q, frame_src_d;
  logic           drv_start_q, drv_start_d;
  logic           vis_ready_q, vis_ready_d;
  logic           diag_ready_q, diag_ready_d;
  logic [15:0]    frames_sent_q, frames_sent_d;

  logic           blank_due;
  logic           grant_vis, grant_diag, grant_blank;

  // Request selection: alternate on a vis/diag tie, blank only when both are quiet
  always_comb begin
    blank_due   = (BLANK_CYCLES > 0) && (idle_cnt_q == IW'(BLANK_CYCLES)) && !blank_sent_q;
    grant_vis   = bus.vis_valid && (!bus.diag_valid || last_diag_q);
    grant_diag  = bus.diag_valid && (!bus.vis_valid || !last_diag_q);
    grant_blank = blank_due && !bus.vis_valid && !bus.diag_valid;
  end

  // Next-state: handshake FSM, holdoff timer, idle/blank tracking and frame counter
  always_comb begin
    state_d       = state_q;
    holdoff_d     = (holdoff_q != '0) ? holdoff_q - 1'b1 : holdoff_q;
    idle_cnt_d    = (idle_cnt_q != IW'(BLANK_CYCLES)) ? idle_cnt_q + 1'b1 : idle_cnt_q;
    blank_sent_d  = blank_sent_q;
    last_diag_d   = last_diag_q;
    drv_rgb_d     = drv_rgb_q;
    frame_src_d   = frame_src_q;
    drv_start_d   = drv_start_q;
    vis_ready_d   = 1'b0;
    diag_ready_d  = 1'b0;
    frames_sent_d = frames_sent_q;

    case (state_q)
      IDLE: begin
        // A driver that reports busy here is ignored; only ARM looks at drv_done
        if (holdoff_q == '0 && (grant_vis || grant_diag || grant_blank)) begin
          drv_start_d = 1'b1;
          holdoff_d   = HW'(MIN_FRAME_CYCLES - 1);
          state_d     = ARM;
          if (grant_vis) begin
            vis_ready_d  = 1'b1;
            drv_rgb_d    = bus.vis_rgb;
            frame_src_d  = SRC_VIS;
            last_diag_d  = 1'b0;
            idle_cnt_d   = '0;
            blank_sent_d = 1'b0;
          end else if (grant_diag) begin
            diag_ready_d = 1'b1;
            drv_rgb_d    = bus.diag_rgb;
            frame_src_d  = SRC_DIAG;
            last_diag_d  = 1'b1;
            idle_cnt_d   = '0;
            blank_sent_d = 1'b0;
          end else begin
            drv_rgb_d    = '0;
            frame_src_d  = SRC_BLANK;
            blank_sent_d = 1'b1;
          end
        end
      end
      ARM: begin
        // Driver has started shifting once it drops done
        if (!bus.drv_done) begin
          drv_start_d = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (bus.drv_done) begin
          frames_sent_d = frames_sent_q + 16'd1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      holdoff_q     <= '0;
      idle_cnt_q    <= '0;
      blank_sent_q  <= 1'b0;
      last_diag_q   <= 1'b1;
      drv_rgb_q     <= '0;
      frame_src_q   <= SRC_NONE;
      drv_start_q   <= 1'b0;
      vis_ready_q   <= 1'b0;
      diag_ready_q  <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      holdoff_q     <= holdoff_d;
      idle_cnt_q    <= idle_cnt_d;
      blank_sent_q  <= blank_sent_d;
      last_diag_q   <= last_diag_d;
      drv_rgb_q     <= drv_rgb_d;
      frame_src_q   <= frame_src_d;
      drv_start_q   <= drv_start_d;
      vis_ready_q   <= vis_ready_d;
      diag_ready_q  <= diag_ready_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign bus.vis_ready   = vis_ready_q;
  assign bus.diag_ready  = diag_ready_q;
  assign bus.drv_start   = drv_start_q;
  assign bus.drv_rgb     = drv_rgb_q;
  assign bus.frame_src   = frame_src_q;
  assign bus.frames_sent = frames_sent_q;
endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: table of frame grants plus hand sequences for
// blanking, counter wrap and reset mid-frame, against a behavioural WS2801 driver.
module tb_led_frame_scheduler;
  localparam int LEDS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   drv_gap = 3;
  int   drv_len = 30;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_frame_scheduler_if #(.LEDS(LEDS)) bus ();

  led_frame_scheduler #(
    .LEDS(LEDS), .MIN_FRAME_CYCLES(100), .BLANK_CYCLES(1000)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Driver model: sees start while idle, waits drv_gap, shifts for drv_len with done low
  initial begin
    bus.drv_done = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && bus.drv_start && bus.drv_done) begin
        repeat (drv_gap) @(negedge clk);
        bus.drv_done = 1'b0;
        repeat (drv_len) @(negedge clk);
        bus.drv_done = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_ready(output logic gv, output logic gd, output int at);
    int n = 0;
    while (!(bus.vis_ready || bus.diag_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    gv = bus.vis_ready;
    gd = bus.diag_ready;
    at = cyc;
    check("ready_seen", 64'(gv | gd), 64'd1);
  endtask

  task automatic wait_sent(input logic [15:0] exp);
    int n = 0;
    while (bus.frames_sent !== exp && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("frames_sent", 64'(bus.frames_sent), 64'(exp));
  endtask

  task automatic wait_src(input logic [1:0] exp, input int limit, output int at);
    int n = 0;
    while (bus.frame_src !== exp && n < limit) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    check("frame_src_seen", 64'(bus.frame_src), 64'(exp));
  endtask

  task automatic wait_start_low();
    int n = 0;
    while (bus.drv_start && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("start_dropped", 64'(bus.drv_start), 64'd0);
  endtask

  typedef struct {
    logic        vv;
    logic        dv;
    logic [47:0] vr;
    logic [47:0] dr;
    logic [1:0]  src;
    logic [47:0] rgb;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic gv, gd;
    int   at, prev_at, blank_at;

    tbl[0] = '{1'b1, 1'b0, 48'h800000_0000FF, 48'h0,              2'b01, 48'h800000_0000FF};
    tbl[1] = '{1'b0, 1'b1, 48'h0,              48'h00FF00_123456, 2'b10, 48'h00FF00_123456};
    tbl[2] = '{1'b1, 1'b1, 48'hAAAAAA_555555, 48'h0F0F0F_F0F0F0, 2'b01, 48'hAAAAAA_555555};
    tbl[3] = '{1'b1, 1'b1, 48'hAAAAAA_555555, 48'h0F0F0F_F0F0F0, 2'b10, 48'h0F0F0F_F0F0F0};
    tbl[4] = '{1'b1, 1'b1, 48'hAAAAAA_555555, 48'h0F0F0F_F0F0F0, 2'b01, 48'hAAAAAA_555555};
    tbl[5] = '{1'b1, 1'b1, 48'hAAAAAA_555555, 48'h0F0F0F_F0F0F0, 2'b10, 48'h0F0F0F_F0F0F0};
    tbl[6] = '{1'b0, 1'b1, 48'h0,              48'h111111_222222, 2'b10, 48'h111111_222222};
    tbl[7] = '{1'b1, 1'b0, 48'h123456_ABCDEF, 48'h0,              2'b01, 48'h123456_ABCDEF};

    bus.vis_valid  = 1'b0;
    bus.diag_valid = 1'b0;
    bus.vis_rgb    = '0;
    bus.diag_rgb   = '0;
    prev_at = 0;

    // Reset state
    #1 rst = 1'b0;
    #1;
    check("rst_vis_ready",  64'(bus.vis_ready),   64'd0);
    check("rst_diag_ready", 64'(bus.diag_ready),  64'd0);
    check("rst_drv_start",  64'(bus.drv_start),   64'd0);
    check("rst_drv_rgb",    64'(bus.drv_rgb),     64'd0);
    check("rst_frame_src",  64'(bus.frame_src),   64'd0);
    check("rst_frames",     64'(bus.frames_sent), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Table: grants, latched data, ready pulse width, holdoff spacing
    for (int i = 0; i < 8; i++) begin
      bus.vis_valid  = tbl[i].vv;
      bus.diag_valid = tbl[i].dv;
      bus.vis_rgb    = tbl[i].vr;
      bus.diag_rgb   = tbl[i].dr;
      wait_ready(gv, gd, at);
      check($sformatf("v%0d_vis_ready", i),  64'(gv), 64'(tbl[i].src == 2'b01));
      check($sformatf("v%0d_diag_ready", i), 64'(gd), 64'(tbl[i].src == 2'b10));
      check($sformatf("v%0d_drv_rgb", i),    64'(bus.drv_rgb), 64'(tbl[i].rgb));
      check($sformatf("v%0d_frame_src", i),  64'(bus.frame_src), 64'(tbl[i].src));
      check($sformatf("v%0d_drv_start", i),  64'(bus.drv_start), 64'd1);
      if (i > 0) check($sformatf("v%0d_spacing", i), 64'(at - prev_at), 64'd100);
      prev_at = at;
      bus.vis_valid  = 1'b0;
      bus.diag_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_ready_1cyc", i), 64'(bus.vis_ready | bus.diag_ready), 64'd0);
      check($sformatf("v%0d_start_held", i), 64'(bus.drv_start), 64'd1);
      wait_sent(16'(i + 1));
      check($sformatf("v%0d_start_low", i), 64'(bus.drv_start), 64'd0);
    end

    // Quiet period: one blank exactly 1000 idle cycles after the last vis accept
    wait_src(2'b11, 1500, blank_at);
    check("blank_delay", 64'(blank_at - prev_at), 64'd1001);
    check("blank_rgb",   64'(bus.drv_rgb), 64'd0);
    check("blank_no_ready", 64'(bus.vis_ready | bus.diag_ready), 64'd0);
    wait_sent(16'd9);
    repeat (5000) @(negedge clk);
    check("no_second_blank", 64'(bus.frames_sent), 64'd9);
    check("blank_src_kept",  64'(bus.frame_src),   64'd3);

    // A vis frame re-arms blanking
    bus.vis_valid = 1'b1;
    bus.vis_rgb   = 48'hFEDCBA_987654;
    wait_ready(gv, gd, at);
    check("rearm_vis_ready", 64'(gv), 64'd1);
    check("rearm_src",       64'(bus.frame_src), 64'd1);
    bus.vis_valid = 1'b0;
    wait_sent(16'd10);
    wait_src(2'b11, 1500, blank_at);
    check("rearm_blank_delay", 64'(blank_at - at), 64'd1001);
    wait_sent(16'd11);

    // Counter wrap from 0xFFFF
    @(negedge clk);
    force dut.frames_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent_q;
    @(negedge clk);
    check("preload", 64'(bus.frames_sent), 64'hFFFF);
    bus.vis_valid = 1'b1;
    bus.vis_rgb   = 48'h000001_000002;
    wait_ready(gv, gd, at);
    bus.vis_valid = 1'b0;
    wait_sent(16'h0000);

    // One more frame so the counter is non-zero, then reset during BUSY
    bus.diag_valid = 1'b1;
    bus.diag_rgb   = 48'h0000FF_FF0000;
    wait_ready(gv, gd, at);
    bus.diag_valid = 1'b0;
    wait_sent(16'd1);
    drv_len = 200;
    bus.diag_valid = 1'b1;
    wait_ready(gv, gd, at);
    check("busy_diag_ready", 64'(gd), 64'd1);
    bus.diag_valid = 1'b0;
    wait_start_low();
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("busyrst_start",  64'(bus.drv_start),   64'd0);
    check("busyrst_ready",  64'(bus.vis_ready | bus.diag_ready), 64'd0);
    check("busyrst_src",    64'(bus.frame_src),   64'd0);
    check("busyrst_frames", 64'(bus.frames_sent), 64'd0);
    check("busyrst_rgb",    64'(bus.drv_rgb),     64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (250) @(negedge clk);
    drv_len = 30;

    // First tie after reset goes to vis
    bus.vis_valid  = 1'b1;
    bus.diag_valid = 1'b1;
    wait_ready(gv, gd, at);
    check("tie_after_rst_vis",  64'(gv), 64'd1);
    check("tie_after_rst_diag", 64'(gd), 64'd0);
    check("tie_after_rst_src",  64'(bus.frame_src), 64'd1);
    bus.vis_valid  = 1'b0;
    bus.diag_valid = 1'b0;
    wait_sent(16'd1);

    // Reset while ARM is holding drv_start
    drv_gap = 50;
    bus.diag_valid = 1'b1;
    wait_ready(gv, gd, at);
    bus.diag_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("arm_start_high", 64'(bus.drv_start), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("armrst_start",  64'(bus.drv_start),   64'd0);
    check("armrst_frames", 64'(bus.frames_sent), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
